uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver with a small receive FIFO; counterpart of the LM32 system UART transmitter.
- Deserialises 8N1 frames on uart_rxd using 16x oversampling.
- Presents received bytes on a valid/ready stream.
- Used both as the bench-side partner that captures the system's uart_txd and as a synthesizable peripheral core.

Parameters:
- clk_freq, 50000000, clock frequency in Hz.
- uart_baud_rate, 115200, line baud rate.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- uart_rxd  in  1  serial input, idle high, asynchronous to clk.
- rx_data  out  8  FIFO head byte; show-ahead.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head byte when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- rx_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0): all outputs 0, rx_level=0, FSM in IDLE, synchroniser flops set to 1, tick and bit counters 0. Reset mid-frame discards the partial byte and the FIFO contents.
- Input path: uart_rxd passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Divisor: DIV = max(1, (clk_freq + 8*uart_baud_rate) / (16*uart_baud_rate)), i.e. rounded to nearest. DIV=27 at the defaults.
- Tick: a free-running counter emits a tick every DIV clocks. The counter is restarted on IDLE->START so sampling stays phase-aligned.
- Oversample counter os (4 bit) counts ticks within a bit. Mid-bit sample point is os==7; a bit ends at os==15.
- IDLE: stay while rxs==1. On rxs==0, go to START, clear os.
- START: at the mid-bit sample, if rxs==0 go to DATA with bit index 0. If rxs==1, treat as a glitch and return to IDLE with no error.
- DATA: sample at mid-bit, shift in LSB first. After bit 7 is sampled and os reaches 15, go to STOP.
- STOP: at the mid-bit sample:
  - rxs==1: push the byte.
  - rxs==0: pulse frame_err, discard the byte.
  - Either way, go to IDLE on the same cycle so a back-to-back start bit is caught within half a bit.
- FIFO push when not full: the byte becomes visible on rx_data / rx_valid on the following cycle if the FIFO was empty (latency 1 clk after the stop-bit sample).
- Push when full with no simultaneous pop: byte dropped, overrun pulses, FIFO unchanged.
- Push and pop in the same cycle: both succeed, including when full or when level==1; rx_level unchanged.
- Pop when empty: ignored.
- Pointers wrap modulo FIFO_DEPTH. rx_level is exact at every cycle.
- frame_err and overrun never assert in the same cycle: a frame error means no push.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state is inserted between DATA and STOP.
  - Parity mismatch raises an extra output parity_err, a one-cycle pulse at the stop-bit sample.
  - A byte with a parity error is discarded, like a framing error.
  - Framing takes priority: if both fail, only frame_err pulses.
- Undefined: 8N1 as above; parity_err port absent.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}.
  - Constants OS_RATE=16 and OS_MID=7.
  - Divisor function calc_div(clk_freq, baud), shared with the transmitter.
- Sub-module rx_sync_fifo: parameterised DEPTH×WIDTH synchronous FIFO with show-ahead output, push/pop/full/empty/level. The FSM and oversampler stay in uart_rx_fifo.

Test Plan (defaults: 50 MHz clock, 115200 baud, 432 clocks per bit):
- Single byte: send 0xA5 with rx_ready=0 -> rx_valid rises within 1 clk after the stop mid-sample; rx_data=0xA5; rx_level=1; no error pulses.
- Back-to-back frames: send 0x00, 0xFF, 0x55 with zero idle gap and rx_ready=1 -> three bytes accepted in order.
- Glitch and frame error:
  - Low pulse of 100 clks on idle line -> no byte, no error.
  - Frame 0x3C with stop bit held low -> frame_err pulses once, rx_level stays 0.
- Overrun: rx_ready=0, send 17 bytes 0x01..0x11 -> rx_level=16, overrun pulses once on byte 17, then drain yields 0x01..0x10.
- Simultaneous push and pop at full: FIFO full, assert rx_ready on the exact push cycle of a new byte -> no overrun, rx_level stays 16, new byte at the tail.
- Reset mid-frame: drop rst after bit 3 of 0xC3 -> all outputs 0 while low. After release, the next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and the
// baud divisor helper also used by the transmitter.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int OS_RATE = 16;
    localparam int OS_MID  = 7;

    // Clocks per oversample tick, rounded to nearest, never below one.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = (clk_freq + (OS_RATE / 2) * baud) / (OS_RATE * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with show-ahead head output and exact level.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
`timescale 1ns/1ps
module rx_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_drop,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // When full, the slot being written is the one being read out this cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && !w_push;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver, 16x oversampled, 8N1 (8E1 with parity_err when UART_RX_PARITY_EN
// is defined), feeding a show-ahead receive FIFO; byte visible 1 clk after stop mid-sample.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 115200,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rxd,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        frame_err,
    output logic                        overrun,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0] rx_level
);

    localparam int DIV = calc_div(clk_freq, uart_baud_rate);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic [DW-1:0] r_div_cnt;
    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic [3:0]  r_os;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_frame_err;
    logic        r_overrun;
    logic        w_rxs;
    logic        w_tick;
    logic        w_mid;
    logic        w_end;
    logic        w_start_det;
    logic        w_push;
    logic        w_ferr;
    logic        w_drop;
    logic        w_empty;
    logic        w_full;
`ifdef UART_RX_PARITY_EN
    logic        r_par;
    logic        r_parity_err;
    logic        w_perr;
`endif

    assign w_rxs       = r_sync2;
    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign w_mid       = w_tick && (r_os == 4'(OS_MID));
    assign w_end       = w_tick && (r_os == 4'(OS_RATE - 1));
    assign w_start_det = (r_state == IDLE) && !w_rxs;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr      = 1'b0;
`endif
        case (r_state)
            IDLE:   if (!w_rxs) w_state_nxt = START;
            START:  if (w_mid) w_state_nxt = w_rxs ? IDLE : DATA;
            DATA: begin
                // Bit count gates the end-of-bit check so the tail of the start bit is ignored.
                if (w_end && r_bit_cnt == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
            PARITY: if (w_end) w_state_nxt = STOP;
            STOP: begin
                if (w_mid) begin
                    w_state_nxt = IDLE;
                    if (!w_rxs) begin
                        w_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (^{r_shift, r_par}) begin
                        w_perr = 1'b1;
`endif
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_div_cnt   <= '0;
            r_state     <= IDLE;
            r_os        <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= uart_rxd;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_frame_err <= w_ferr;
            r_overrun   <= w_drop;
            if (w_start_det) begin
                r_div_cnt <= '0;
                r_os      <= '0;
                r_bit_cnt <= '0;
            end else begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                if (w_tick) r_os <= r_os + 1'b1;
            end
            if (r_state == DATA && w_mid) begin
                r_shift   <= {w_rxs, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr;
            if (r_state == PARITY && w_mid) r_par <= w_rxs;
        end
    end

    assign parity_err = r_parity_err;
`endif

    rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (rx_ready),
        .o_data  (rx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_level (rx_level)
    );

    assign rx_valid  = !w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    // Full status is already folded into the FIFO's drop indication.
    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand-written
// back-to-back, glitch, overrun, full push/pop and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int BAUD  = 115200;
    localparam int CLKF  = 14745600;   // divisor 8 -> 128 clocks per bit
    localparam int DEPTH = 16;
    localparam int BIT   = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic [4:0] rx_level;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic [7:0] rcv_q [$];

    uart_rx_fifo #(
        .clk_freq       (CLKF),
        .uart_baud_rate (BAUD),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .rx_level  (rx_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_valid && rx_ready) rcv_q.push_back(rx_data);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A bad stop bit is held low just past its mid-sample, then the line idles.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        if (stop_ok) begin
            drive(1'b1, BIT);
        end else begin
            drive(1'b0, 80);
            drive(1'b1, BIT - 80);
        end
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       exp_vld;
        logic [7:0] exp_dat;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int cnt;
        logic [7:0] exp_b;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};

        idle(5);
        check("reset_valid", rx_valid, 0);
        check("reset_level", rx_level, 0);
        check("reset_data", rx_data, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        rst = 1'b1;
        idle(BIT);

        // Single byte: latency from start edge to rx_valid.
        cnt = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!rx_valid && cnt < 2000) begin
                    @(negedge clk);
                    cnt++;
                end
            end
        join
        check("lat_window", (cnt >= 9*BIT + BIT/2 && cnt <= 9*BIT + BIT/2 + 8) ? 1 : 0, 1);
        check("single_data", rx_data, 8'hA5);
        check("single_level", rx_level, 1);
        check("single_ferr", ferr_cnt, 0);
        pop_one();
        idle(4);

        for (int v = 0; v < 5; v++) begin
            ferr_cnt = 0;
            ovr_cnt  = 0;
            send_frame(vecs[v].data, vecs[v].stop_ok);
            idle(2*BIT);
            check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_vld);
            check($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_dat);
            check($sformatf("vec%0d_level", v), rx_level, vecs[v].exp_vld ? 1 : 0);
            check($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ovr", v), ovr_cnt, 0);
            pop_one();
            idle(4);
        end

        // Glitch shorter than half a bit.
        ferr_cnt = 0;
        drive(1'b0, 40);
        drive(1'b1, 3*BIT);
        check("glitch_valid", rx_valid, 0);
        check("glitch_ferr", ferr_cnt, 0);

        // Back-to-back frames with the consumer always ready.
        rcv_q.delete();
        rx_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(BIT);
        rx_ready = 1'b0;
        check("b2b_count", rcv_q.size(), 3);
        if (rcv_q.size() == 3) begin
            check("b2b_0", rcv_q[0], 8'h00);
            check("b2b_1", rcv_q[1], 8'hFF);
            check("b2b_2", rcv_q[2], 8'h55);
        end

        // Overrun: 17 bytes into a 16-entry FIFO.
        ferr_cnt = 0;
        ovr_cnt  = 0;
        rcv_q.delete();
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1);
        idle(BIT);
        check("ovr_level", rx_level, 16);
        check("ovr_pulses", ovr_cnt, 1);
        check("ovr_ferr", ferr_cnt, 0);

        // Pop on the exact push cycle of a new byte while full.
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (9*BIT + BIT/2 + 2) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(negedge clk);
                check("simul_level_pre", rx_level, 16);
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
                @(negedge clk);
                check("simul_level_post", rx_level, 16);
            end
        join
        idle(BIT);
        check("simul_ovr", ovr_cnt, 1);
        rx_ready = 1'b1;
        idle(24);
        rx_ready = 1'b0;
        check("drain_count", rcv_q.size(), 17);
        for (int i = 0; i < 17; i++) begin
            exp_b = (i < 16) ? 8'(i + 1) : 8'h99;
            if (i < rcv_q.size()) check($sformatf("drain_%0d", i), rcv_q[i], exp_b);
        end
        check("drain_level", rx_level, 0);

        // Reset mid-frame with a byte already buffered.
        send_frame(8'h11, 1'b1);
        idle(8);
        check("prereset_level", rx_level, 1);
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (5*BIT + 20) @(posedge clk);
                #1;
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("rst_valid", rx_valid, 0);
                check("rst_data", rx_data, 0);
                check("rst_level", rx_level, 0);
                check("rst_ferr", frame_err, 0);
                check("rst_ovr", overrun, 0);
            end
        join
        idle(5);
        rst = 1'b1;
        idle(BIT);
        ferr_cnt = 0;
        send_frame(8'h7E, 1'b1);
        idle(BIT);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'h7E);
        check("post_rst_level", rx_level, 1);
        check("post_rst_ferr", ferr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
